// File: rtl/regfile_mp.sv
// Multi-read-port register file with same-cycle write bypass and a pending-write scoreboard.
// Storage is cleared one entry per cycle after reset or i_clear so the array stays RAM-mappable.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_clear,
  output logic                o_busy,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [XLEN-1:0]     i_wdata,
  input  logic                i_rsv_en,
  input  logic [AW-1:0]       i_rsv_addr,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_pending
);

  // state   | meaning
  // S_IDLE  | normal operation: writes, reservations, reads
  // S_CLEAR | zeroing mem[ptr] each cycle; all accesses ignored
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            clr_wr;
  logic            idle;
  logic            wr_ok;
  logic            rsv_ok;
  logic            fwd_ok;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  assign idle   = (state_q == S_IDLE);
  assign o_busy = (state_q == S_CLEAR);

  // rst drops any write presented in the same cycle.
  assign wr_ok  = idle && clk_en && i_we && !rst && !(ZERO_REG && (i_waddr == '0));
  assign rsv_ok = idle && clk_en && i_rsv_en && !rst;
  assign fwd_ok = BYPASS && idle && clk_en && i_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_wr = 1'b1;
        if (i_clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Single write port: clear and normal writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (clr_wr && !rst) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // A reservation is applied after the write's release so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (idle && clk_en && i_we) pend_d[i_waddr] = 1'b0;
    if (rsv_ok) pend_d[i_rsv_addr] = 1'b1;
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !idle || i_clear) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rdata;
    logic            pend;

    assign addr = i_raddr[k*AW +: AW];

    always_comb begin
      rdata = '0;
      pend  = 1'b0;
      if (!o_busy) begin
        if (ZERO_REG && (addr == '0)) begin
          rdata = '0;
          pend  = 1'b0;
        end else if (fwd_ok && (i_waddr == addr)) begin
          rdata = i_wdata;
          pend  = 1'b0;
        end else begin
          rdata = mem[addr];
          pend  = pend_q[addr];
        end
      end
    end

    assign o_rdata[k*XLEN +: XLEN] = rdata;
    assign o_pending[k]            = pend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share all stimulus.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        i_clear;
  logic        i_we;
  logic [4:0]  i_waddr;
  logic [31:0] i_wdata;
  logic        i_rsv_en;
  logic [4:0]  i_rsv_addr;
  logic [9:0]  i_raddr;
  logic        busy, busy_nb;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  pend, pend_nb;

  int vectors = 0;
  int errs    = 0;
  int n;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_clear(i_clear), .o_busy(busy),
    .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr),
    .i_raddr(i_raddr), .o_rdata(rdata), .o_pending(pend)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_clear(i_clear), .o_busy(busy_nb),
    .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr),
    .i_raddr(i_raddr), .o_rdata(rdata_nb), .o_pending(pend_nb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input int a0, input int a1);
    i_raddr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; i_clear = 1'b0; i_we = 1'b0;
    i_waddr = '0; i_wdata = '0; i_rsv_en = 1'b0; i_rsv_addr = '0; i_raddr = '0;

    // reset and power-on clear
    tick;
    rst = 1'b0;
    #1;
    chk("reset_busy", busy, 1);
    chk("reset_rdata", rdata, 0);
    chk("reset_pending", pend, 0);
    n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    chk("clear_cycles", n, 32);
    chk("clear_cycles_nb", busy_nb, 0);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1;
      chk($sformatf("post_clear_x%0d", a), rdata, 0);
    end

    // write x5, same-cycle bypass vs none
    tick;
    i_we = 1'b1; i_waddr = 5'd5; i_wdata = 32'hDEADBEEF; set_rd(5, 5);
    #1;
    chk("bypass_x5", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("nobypass_x5", rdata_nb, 0);
    tick;
    i_we = 1'b0;
    #1;
    chk("x5_next", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("x5_next_nb", rdata_nb, {32'hDEADBEEF, 32'hDEADBEEF});

    // zero register ignores writes and reservations
    i_we = 1'b1; i_waddr = 5'd0; i_wdata = 32'h12345678;
    i_rsv_en = 1'b1; i_rsv_addr = 5'd0; set_rd(0, 0);
    #1;
    chk("x0_same", rdata, 0);
    chk("x0_pend_same", pend, 0);
    tick;
    i_we = 1'b0; i_rsv_en = 1'b0;
    #1;
    chk("x0_next", rdata, 0);
    chk("x0_pend_next", pend, 0);

    // scoreboard
    i_rsv_en = 1'b1; i_rsv_addr = 5'd7; set_rd(7, 5);
    #1;
    chk("rsv_x7_same", pend, 2'b00);
    tick;
    i_rsv_en = 1'b0; set_rd(7, 7);
    #1;
    chk("rsv_x7_next", pend, 2'b11);
    set_rd(7, 5);
    #1;
    chk("rsv_x7_port0_only", pend, 2'b01);
    i_we = 1'b1; i_waddr = 5'd7; i_wdata = 32'h55;
    #1;
    chk("wr_x7_masked", pend, 2'b00);
    chk("wr_x7_bypass", rdata, {32'hDEADBEEF, 32'h55});
    chk("wr_x7_nb_pend", pend_nb, 2'b01);
    tick;
    i_we = 1'b0;
    #1;
    chk("wr_x7_released", pend, 2'b00);
    chk("wr_x7_data", rdata[31:0], 32'h55);
    i_we = 1'b1; i_waddr = 5'd7; i_wdata = 32'h66;
    i_rsv_en = 1'b1; i_rsv_addr = 5'd7;
    tick;
    i_we = 1'b0; i_rsv_en = 1'b0;
    #1;
    chk("rsv_wr_same_pend", pend, 2'b01);
    chk("rsv_wr_same_data", rdata[31:0], 32'h66);

    // clk_en gating
    clk_en = 1'b0; i_we = 1'b1; i_waddr = 5'd3; i_wdata = 32'h9;
    i_rsv_en = 1'b1; i_rsv_addr = 5'd3; set_rd(3, 7);
    #1;
    chk("cken0_no_bypass", rdata[31:0], 0);
    tick;
    chk("cken0_no_write", rdata[31:0], 0);
    chk("cken0_no_rsv", pend, 2'b10);
    i_rsv_en = 1'b0;
    clk_en = 1'b1;
    tick;
    i_we = 1'b0;
    #1;
    chk("cken1_write", rdata[31:0], 32'h9);

    // sequential clear, with rst restart mid-clear
    i_we = 1'b1; i_waddr = 5'd4; i_wdata = 32'hA; i_clear = 1'b1; set_rd(4, 5);
    tick;
    i_clear = 1'b0; i_wdata = 32'hB;
    #1;
    chk("clr_busy", busy, 1);
    chk("clr_rdata_gated", rdata, 0);
    for (int i = 0; i < 9; i++) tick;
    chk("clr_busy_mid", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    chk("clr_restart_cycles", n, 32);
    i_we = 1'b0; set_rd(4, 7);
    #1;
    chk("clr_x4_zero", rdata[31:0], 0);
    chk("clr_x7_zero", rdata[63:32], 0);
    chk("clr_pend", pend, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
